rv_muldiv_unit: RTL and testbench

- Standalone, parametrised RV M-extension multiply/divide unit with a valid/ready handshake on both input and output.
- Successor to the multiply/divide logic currently inlined in the rv32i execute stage.
- Generalised in operand width and divider radix (bits retired per cycle).
- Adds two behaviours the inline version lacks: explicit signed-overflow handling and a kill/flush input.
- Sits beside the ALU in the execute stage; the core stalls on in_ready/out_valid.

---
 rtl/rv_muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: RV M-extension multiply/divide unit with valid/ready on both sides.
// Multiplies and divide corner cases (divide by zero, signed overflow) complete in
// one cycle. Other divides run a restoring divider that retires DIV_BITS quotient
// bits per cycle.
module rv_muldiv_unit #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned DIV_BITS = 1,
   parameter int unsigned TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_op1,
   input  logic [XLEN-1:0]  in_op2,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int unsigned ITERS = XLEN / DIV_BITS;
   localparam int unsigned CNT_W = $clog2(ITERS);
   localparam int unsigned PW    = 2 * XLEN;

   typedef enum logic [1:0] {IDLE, DIV_ITER, DONE} state_t;

   state_t             r_state;
   state_t             w_next;

   logic [XLEN-1:0]    r_result;
   logic [TAG_W-1:0]   r_tag;
   logic [XLEN-1:0]    r_rem;
   logic [XLEN-1:0]    r_quo;
   logic [XLEN-1:0]    r_dvsr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_rem;
   logic               r_neg_q;
   logic               r_neg_r;

   logic               w_accept;
   logic               w_is_div;
   logic               w_signed_div;
   logic               w_op2_zero;
   logic               w_ovf;
   logic               w_fast_div;
   logic               w_op1_neg;
   logic               w_op2_neg;
   logic [XLEN-1:0]    w_mag1;
   logic [XLEN-1:0]    w_mag2;
   logic [XLEN-1:0]    w_fast_result;
   logic               w_a_sx;
   logic               w_b_sx;
   logic [PW-1:0]      w_mul_a;
   logic [PW-1:0]      w_mul_b;
   logic [PW-1:0]      w_prod;
   logic [XLEN-1:0]    w_mul_result;
   logic [XLEN:0]      w_rem_step;
   logic [XLEN-1:0]    w_quo_step;
   logic [XLEN-1:0]    w_quo_fix;
   logic [XLEN-1:0]    w_rem_fix;
   logic [XLEN-1:0]    w_div_result;

   assign in_ready   = (r_state == IDLE) && !kill;
   assign out_valid  = (r_state == DONE);
   assign busy       = (r_state != IDLE);
   assign out_result = r_result;
   assign out_tag    = r_tag;

   // Request decode at accept: op class, corner cases and operand magnitudes
   assign w_accept     = in_valid && in_ready;
   assign w_is_div     = in_funct3[2];
   assign w_signed_div = !in_funct3[0];
   assign w_op2_zero   = (in_op2 == '0);
   assign w_ovf        = w_signed_div && (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_op2 == '1);
   assign w_fast_div   = w_op2_zero || w_ovf;
   assign w_op1_neg    = w_signed_div && in_op1[XLEN-1];
   assign w_op2_neg    = w_signed_div && in_op2[XLEN-1];
   assign w_mag1       = w_op1_neg ? -in_op1 : in_op1;
   assign w_mag2       = w_op2_neg ? -in_op2 : in_op2;

   // Single-cycle divide results: divide by zero wins over signed overflow
   always_comb begin
      w_fast_result = '0;
      if (w_op2_zero) begin
         w_fast_result = in_funct3[1] ? in_op1 : '1;
      end else begin
         w_fast_result = in_funct3[1] ? '0 : in_op1;
      end
   end

   // Full-width product; operand sign extension selects MULH/MULHSU/MULHU
   assign w_a_sx       = (in_funct3[1:0] == 2'd1) || (in_funct3[1:0] == 2'd2);
   assign w_b_sx       = (in_funct3[1:0] == 2'd1);
   assign w_mul_a      = {{XLEN{w_a_sx && in_op1[XLEN-1]}}, in_op1};
   assign w_mul_b      = {{XLEN{w_b_sx && in_op2[XLEN-1]}}, in_op2};
   assign w_prod       = w_mul_a * w_mul_b;
   assign w_mul_result = (in_funct3[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];

   // DIV_BITS restoring steps per cycle; dividend shifts out of r_quo as quotient shifts in
   always_comb begin
      w_rem_step = {1'b0, r_rem};
      w_quo_step = r_quo;
      for (int i = 0; i < DIV_BITS; i++) begin
         w_rem_step = {w_rem_step[XLEN-1:0], w_quo_step[XLEN-1]};
         w_quo_step = {w_quo_step[XLEN-2:0], 1'b0};
         if (w_rem_step >= {1'b0, r_dvsr}) begin
            w_rem_step    = w_rem_step - {1'b0, r_dvsr};
            w_quo_step[0] = 1'b1;
         end
      end
   end

   // Sign fix-up applied as the last step retires
   assign w_quo_fix    = r_neg_q ? -w_quo_step : w_quo_step;
   assign w_rem_fix    = r_neg_r ? -w_rem_step[XLEN-1:0] : w_rem_step[XLEN-1:0];
   assign w_div_result = r_is_rem ? w_rem_fix : w_quo_fix;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; kill overrides everything
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = (w_is_div && !w_fast_div) ? DIV_ITER : DONE;
            end
         end
         DIV_ITER: begin
            if (r_cnt == '0) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
      if (kill) begin
         w_next = IDLE;
      end
   end

   // Datapath: latch request at accept, iterate divider, capture result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_tag    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvsr   <= '0;
         r_cnt    <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else if (w_accept) begin
         r_tag    <= in_tag;
         r_is_rem <= in_funct3[1];
         r_neg_q  <= w_op1_neg ^ w_op2_neg;
         r_neg_r  <= w_op1_neg;
         r_quo    <= w_mag1;
         r_dvsr   <= w_mag2;
         r_rem    <= '0;
         r_cnt    <= CNT_W'(ITERS - 1);
         if (!w_is_div) begin
            r_result <= w_mul_result;
         end else if (w_fast_div) begin
            r_result <= w_fast_result;
         end
      end else if ((r_state == DIV_ITER) && !kill) begin
         r_rem <= w_rem_step[XLEN-1:0];
         r_quo <= w_quo_step;
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == '0) begin
            r_result <= w_div_result;
         end
      end
   end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_rv_muldiv_unit;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_op1 = '0;
   logic [31:0] in_op2 = '0;
   logic [4:0]  in_tag = '0;
   logic        kill = 1'b0;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        busy;

   logic        d4_in_valid = 1'b0;
   logic        d4_in_ready;
   logic        d4_out_valid;
   logic [31:0] d4_out_result;
   logic [4:0]  d4_out_tag;
   logic        d4_busy;

   logic        rand_ready = 1'b0;
   logic        rr = 1'b1;
   logic        dir_ready = 1'b1;
   assign out_ready = rand_ready ? rr : dir_ready;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   bit   seen = 1'b0;

   rv_muldiv_unit #(.XLEN(32), .DIV_BITS(1), .TAG_W(5)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_funct3(in_funct3), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
      .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy));

   rv_muldiv_unit #(.XLEN(32), .DIV_BITS(4), .TAG_W(5)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
      .in_funct3(3'd5), .in_op1(32'd100), .in_op2(32'd7), .in_tag(5'd19),
      .kill(1'b0), .out_valid(d4_out_valid), .out_ready(1'b1),
      .out_result(d4_out_result), .out_tag(d4_out_tag), .busy(d4_busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: M-extension semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      bit          ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f3)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return 1;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         6: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Present one request, wait for accept (bounded), optionally push its expectation
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input bit push, input logic [31:0] exp,
                        input int lat);
      int  w;
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1; in_funct3 = f3; in_op1 = a; in_op2 = b; in_tag = tag;
      w = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         w++;
         if (w > 500) begin
            chk("accept_timeout", 64'(w), 64'd0);
            break;
         end
      end
      if (push && in_ready) begin
         e.res = exp; e.tag = tag; e.lat = lat; e.acc = cyc;
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Monitor: checks first-valid latency and the result at each output handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
               end
               if (out_ready) begin
                  e = q.pop_front();
                  seen = 1'b0;
                  chk("result", 64'(out_result), 64'(e.res));
                  chk("tag", 64'(out_tag), 64'(e.tag));
               end
            end
         end
      end
   end

   // Random consumer backpressure, active only in the random phase
   initial begin
      forever begin
         @(posedge clk); #1;
         rr = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      logic [31:0] a, b, hold_res;
      logic [2:0]  f3;
      logic [4:0]  hold_tag;
      int          acc, w;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Radix-16 instance: DIVU 100/7 in 9 cycles
      @(posedge clk); #1 d4_in_valid = 1'b1;
      @(negedge clk);
      chk("d4_in_ready", 64'(d4_in_ready), 64'd1);
      acc = cyc;
      @(posedge clk); #1 d4_in_valid = 1'b0;
      w = 0;
      while (!d4_out_valid && w < 100) begin @(negedge clk); w++; end
      chk("d4_latency", 64'(cyc - acc), 64'd9);
      chk("d4_result", 64'(d4_out_result), 64'd14);
      chk("d4_tag", 64'(d4_out_tag), 64'd19);

      // Directed operations from the plan
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'h0000_0000, 1);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'hFFFF_FFFE, 1);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'hFFFF_FFFF, 1);
      issue(3'd0, 32'd7, -32'd3, 5'd4, 1'b1, 32'hFFFF_FFEB, 1);
      issue(3'd4, -32'd7, 32'd2, 5'd5, 1'b1, 32'hFFFF_FFFD, 33);
      issue(3'd6, -32'd7, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFF, 33);
      issue(3'd5, 32'd100, 32'd7, 5'd7, 1'b1, 32'd14, 33);
      issue(3'd4, 32'd5, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFFF, 1);
      issue(3'd7, 32'd5, 32'd0, 5'd9, 1'b1, 32'd5, 1);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h8000_0000, 1);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'd0, 1);

      // Backpressure: result and tag hold while out_ready is low
      w = 0;
      while (q.size() != 0 && w < 200) begin @(negedge clk); w++; end
      @(posedge clk); #1 dir_ready = 1'b0;
      issue(3'd0, 32'd1234, 32'd10, 5'd12, 1'b1, 32'd12340, 1);
      w = 0;
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      hold_res = 32'd12340;
      hold_tag = 5'd12;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold", {27'd0, out_tag, out_result, in_ready}, {27'd0, hold_tag, hold_res, 1'b0});
      end
      @(posedge clk); #1 dir_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);

      // kill together with in_valid in IDLE: no accept
      @(posedge clk); #1;
      in_valid = 1'b1; kill = 1'b1; in_funct3 = 3'd0; in_tag = 5'd30;
      @(negedge clk);
      chk("kill_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0;
      @(negedge clk);
      chk("kill_no_accept", 64'(busy), 64'd0);

      // kill at the tenth divide iteration
      issue(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd13, 1'b0, 32'd0, 0);
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1 kill = 1'b0;
      @(negedge clk);
      chk("kill_busy", 64'(busy), 64'd0);
      chk("kill_out_valid", 64'(out_valid), 64'd0);
      repeat (40) @(negedge clk);
      chk("kill_no_late_valid", 64'(out_valid), 64'd0);
      issue(3'd0, 32'd6, 32'd7, 5'd14, 1'b1, 32'd42, 1);
      w = 0;
      while (q.size() != 0 && w < 50) begin @(negedge clk); w++; end

      // Reset during divide iteration
      issue(3'd5, 32'hFFFF_0000, 32'd9, 5'd15, 1'b0, 32'd0, 0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_result", 64'(out_result), 64'd0);
      chk("midrst_out_tag", 64'(out_tag), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1 rst = 1'b0;

      // Randomized ops with random consumer backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         issue(f3, a, b, 5'($urandom), 1'b1, ref_model(f3, a, b), ref_lat(f3, a, b));
      end
      w = 0;
      while (q.size() != 0 && w < 2000) begin @(negedge clk); w++; end
      chk("drain_queue_empty", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
